// File: rtl/de_mem_arbiter_pkg.sv
// Shared types and helpers for the decrypted-message RAM arbiter.
// Holds the FSM state type, default bus widths and the round-robin pick function.
package de_mem_pkg;

    localparam int DE_ADDR_W = 8;
    localparam int DE_DATA_W = 8;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One-hot first set bit of req at or after ptr, searching circularly over n requesters.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input int                 ptr,
                                                   input int                 n);
        logic found;
        int   idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && req[idx[2:0]]) begin
                rr_pick[idx[2:0]] = 1'b1;
                found             = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/de_mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the arbiter.
// slave is the arbiter's view; master is the clients/RAM view.
interface de_mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ-1:0]        req_rd;
    logic [DATA_W-1:0]         rd_data;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data;
    logic                      mem_wren;
    logic [DATA_W-1:0]         mem_q;
    logic                      busy;

    modport slave (
        input  req, req_addr, req_wdata, req_wr, req_rd, mem_q,
        output gnt, rd_data, rd_valid, mem_addr, mem_data, mem_wren, busy
    );

    modport master (
        output req, req_addr, req_wdata, req_wr, req_rd, mem_q,
        input  gnt, rd_data, rd_valid, mem_addr, mem_data, mem_wren, busy
    );

endinterface

// File: rtl/de_mem_arbiter_rr_priority_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr wins.
module rr_priority_pick
    import de_mem_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic               o_any
);

    logic [MAX_REQ-1:0] w_req_pad;
    logic [MAX_REQ-1:0] w_pick;

    // NOTE: every variable driven in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        w_req_pad              = '0;
        w_req_pad[NUM_REQ-1:0] = i_req;
        w_pick                 = rr_pick(w_req_pad, int'(i_rr_ptr), NUM_REQ);
    end

    assign o_winner = w_pick[NUM_REQ-1:0];
    assign o_any    = |i_req;

endmodule

// File: rtl/de_mem_arbiter.sv
// Burst-locked round-robin arbiter for the single-port de_memory RAM.
// Muxes the owner's access onto the RAM and tags read data back to the issuer.
module de_mem_arbiter
    import de_mem_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DE_ADDR_W,
    parameter int DATA_W  = DE_DATA_W,
    parameter int RD_LAT  = 1
) (
    input  logic            clk,
    input  logic            reset,
    de_mem_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [PTR_W-1:0]   r_owner, w_owner_nxt;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [NUM_REQ-1:0] w_winner;
    logic [PTR_W-1:0]   w_winner_id;
    logic               w_any;
    logic               w_owner_req;
    logic               w_rd_issue;
    logic [RD_LAT-1:0]  r_rd_vld, w_rd_vld_nxt;
    logic [PTR_W-1:0]   r_rd_id [RD_LAT];

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    always_comb begin
        w_winner_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) w_winner_id = PTR_W'(i);
        end
    end

    assign w_owner_req = |(r_gnt & bus.req);
    // A simultaneous write wins; the read strobe is dropped.
    assign w_rd_issue  = |(r_gnt & bus.req_rd & ~bus.req_wr);

    always_comb begin
        w_rd_vld_nxt    = '0;
        w_rd_vld_nxt[0] = w_rd_issue;
        for (int i = 1; i < RD_LAT; i++) begin
            w_rd_vld_nxt[i] = r_rd_vld[i-1];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_winner;
                    w_owner_nxt = w_winner_id;
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                    // Reads issued in the release cycle must still be delivered.
                    w_state_nxt  = (|w_rd_vld_nxt) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!(|w_rd_vld_nxt)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            // NOTE: the tag pipeline is tiny, so ids are reset with the valids to keep state deterministic.
            r_rd_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) r_rd_id[i] <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_rd_vld <= w_rd_vld_nxt;
            r_rd_id[0] <= r_owner;
            for (int i = 1; i < RD_LAT; i++) r_rd_id[i] <= r_rd_id[i-1];
        end
    end

    always_comb begin
        bus.mem_addr = '0;
        bus.mem_data = '0;
        if (|r_gnt) begin
            bus.mem_addr = bus.req_addr[r_owner*ADDR_W +: ADDR_W];
            bus.mem_data = bus.req_wdata[r_owner*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        bus.rd_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rd_valid[i] = r_rd_vld[RD_LAT-1] && (r_rd_id[RD_LAT-1] == PTR_W'(i));
        end
    end

    assign bus.mem_wren = |(r_gnt & bus.req_wr);
    assign bus.gnt      = r_gnt;
    assign bus.rd_data  = bus.mem_q;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_de_mem_arbiter.sv
// Self-checking bench for de_mem_arbiter: vector table for grant ordering, scoreboard for reads,
// hand-written sequences for drain, non-owner strobes and asynchronous reset.
module tb_de_mem_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int RD_LAT  = 1;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [NUM_REQ-1:0] gnt;
        logic               busy;
    } vec_t;

    typedef struct {
        logic [NUM_REQ-1:0] onehot;
        logic [DATA_W-1:0]  data;
        int                 due;
    } rd_exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc;

    logic [DATA_W-1:0] ram [256];
    logic [DATA_W-1:0] mem_q_r;
    rd_exp_t           sb[$];
    rd_exp_t           mon_e;
    vec_t              vecs[18];

    de_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    de_mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM with one cycle of read latency.
    initial for (int i = 0; i < 256; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
        mem_q_r <= ram[bus.mem_addr];
    end
    assign bus.mem_q = mem_q_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int id, input logic [7:0] addr, input logic [7:0] data,
                            input logic wr, input logic rd);
        bus.req_addr[id*ADDR_W +: ADDR_W]  = addr;
        bus.req_wdata[id*DATA_W +: DATA_W] = data;
        bus.req_wr[id]                     = wr;
        bus.req_rd[id]                     = rd;
    endtask

    task automatic push_read(input int id, input logic [7:0] data);
        rd_exp_t e;
        e.onehot = NUM_REQ'(1) << id;
        e.data   = data;
        e.due    = cyc + RD_LAT;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid !== '0) begin
            if (sb.size() == 0) begin
                check("rd_unexpected", 32'(bus.rd_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rd_valid_id", 32'(bus.rd_valid), 32'(mon_e.onehot));
                check("rd_data", 32'(bus.rd_data), 32'(mon_e.data));
                check("rd_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Grant-ordering table: req applied before an edge, gnt/busy expected after it.
        vecs[0]  = '{3'b111, 3'b001, 1'b1};
        vecs[1]  = '{3'b111, 3'b001, 1'b1};
        vecs[2]  = '{3'b111, 3'b001, 1'b1};
        vecs[3]  = '{3'b111, 3'b001, 1'b1};
        vecs[4]  = '{3'b110, 3'b000, 1'b0};
        vecs[5]  = '{3'b110, 3'b010, 1'b1};
        vecs[6]  = '{3'b110, 3'b010, 1'b1};
        vecs[7]  = '{3'b110, 3'b010, 1'b1};
        vecs[8]  = '{3'b110, 3'b010, 1'b1};
        vecs[9]  = '{3'b101, 3'b000, 1'b0};
        vecs[10] = '{3'b101, 3'b100, 1'b1};
        vecs[11] = '{3'b101, 3'b100, 1'b1};
        vecs[12] = '{3'b101, 3'b100, 1'b1};
        vecs[13] = '{3'b101, 3'b100, 1'b1};
        vecs[14] = '{3'b001, 3'b000, 1'b0};
        vecs[15] = '{3'b001, 3'b001, 1'b1};
        vecs[16] = '{3'b000, 3'b000, 1'b0};
        vecs[17] = '{3'b000, 3'b000, 1'b0};

        reset         = 1'b0;
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wr    = '0;
        bus.req_rd    = '0;
        tick();
        tick();
        check("reset_gnt", 32'(bus.gnt), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("reset_mem_wren", 32'(bus.mem_wren), 32'd0);
        check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Test 1: requester 0 writes 0x00..0x1F to 0..31.
        tick();
        bus.req = 3'b001;
        tick();
        check("t1_gnt", 32'(bus.gnt), 32'b001);
        for (int i = 0; i < 32; i++) begin
            set_slot(0, 8'(i), 8'(i), 1'b1, 1'b0);
            #1;
            check("t1_mem_wren", 32'(bus.mem_wren), 32'd1);
            check("t1_mem_addr", 32'(bus.mem_addr), 32'(i));
            check("t1_mem_data", 32'(bus.mem_data), 32'(i));
            tick();
        end
        set_slot(0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.req = 3'b000;
        tick();
        check("t1_release_gnt", 32'(bus.gnt), 32'd0);
        check("t1_release_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 32; i++) check("t1_ram", 32'(ram[i]), 32'(i));

        // Test 2: fresh reset so rr_ptr starts at 0, then the grant-ordering table.
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        for (int k = 0; k < 18; k++) begin
            bus.req = vecs[k].req;
            tick();
            check($sformatf("t2_gnt[%0d]", k), 32'(bus.gnt), 32'(vecs[k].gnt));
            check($sformatf("t2_busy[%0d]", k), 32'(bus.busy), 32'(vecs[k].busy));
        end

        // Test 3: owner 1 reads 5..8 back to back (rr_ptr is 1 after owner 0 released).
        bus.req = 3'b010;
        tick();
        check("t3_gnt", 32'(bus.gnt), 32'b010);
        for (int i = 5; i <= 8; i++) begin
            set_slot(1, 8'(i), 8'h00, 1'b0, 1'b1);
            push_read(1, 8'(i));
            tick();
        end

        // Test 4: owner 1 drops req together with its last read; requester 0 waits.
        bus.req = 3'b001;
        set_slot(1, 8'd9, 8'h00, 1'b0, 1'b1);
        push_read(1, 8'd9);
        tick();
        set_slot(1, 8'd0, 8'h00, 1'b0, 1'b0);
        check("t4_drain_gnt", 32'(bus.gnt), 32'd0);
        check("t4_drain_busy", 32'(bus.busy), 32'd1);
        check("t4_drain_rd_valid", 32'(bus.rd_valid), 32'b010);
        tick();
        check("t4_idle_gnt", 32'(bus.gnt), 32'd0);
        check("t4_idle_busy", 32'(bus.busy), 32'd0);
        check("t4_idle_rd_valid", 32'(bus.rd_valid), 32'd0);
        tick();
        check("t4_next_gnt", 32'(bus.gnt), 32'b001);

        // Test 5: non-owner 2 strobes a write while 0 owns the port.
        bus.req = 3'b101;
        set_slot(0, 8'h10, 8'h00, 1'b0, 1'b0);
        set_slot(2, 8'h03, 8'hAA, 1'b1, 1'b0);
        #1;
        check("t5_mem_wren", 32'(bus.mem_wren), 32'd0);
        check("t5_mem_addr", 32'(bus.mem_addr), 32'h10);
        tick();
        check("t5_no_preempt", 32'(bus.gnt), 32'b001);
        set_slot(2, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.req = 3'b000;
        tick();
        check("t5_release_gnt", 32'(bus.gnt), 32'd0);
        check("t5_ram_addr3", 32'(ram[3]), 32'h03);

        // Test 6: asynchronous reset in the middle of a write burst.
        bus.req = 3'b001;
        tick();
        check("t6_gnt", 32'(bus.gnt), 32'b001);
        set_slot(0, 8'h40, 8'h55, 1'b1, 1'b0);
        #1;
        check("t6_wren_before", 32'(bus.mem_wren), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("t6_async_gnt", 32'(bus.gnt), 32'd0);
        check("t6_async_wren", 32'(bus.mem_wren), 32'd0);
        check("t6_async_busy", 32'(bus.busy), 32'd0);
        set_slot(0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.req = 3'b110;
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("t6_post_reset_gnt", 32'(bus.gnt), 32'b010);
        check("t6_ram_untouched", 32'(ram[8'h40]), 32'd0);
        bus.req = 3'b000;
        tick();
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
